disp_sched: RTL and testbench
=============================

DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter: DWELL, default 100000000, display dwell time per page in clk cycles; legal range 2..2^27-1.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  3  bit i = requester i wants the display.
REQ-005 Port: data0, data1, data2  input  32 each  eight hex nibbles per requester; bits 31:28 drive d1, bits 3:0 drive d8.
REQ-006 Port: mask0, mask1, mask2  input  8 each  digit enables per requester; bit 7 drives d1, bit 0 drives d8.
REQ-007 Port: hold  input  1  freeze rotation on the current page.
REQ-008 Port: d1..d8  output  6 each  digit field {en, hex[3:0], dp}, sized for the 8-digit display driver inputs.
REQ-009 Port: gnt  output  3  one-hot grant, 000 = no requester shown.
REQ-010 Port: busy  output  1  high while a requester is granted.

Function
REQ-011 The block SHALL implement two states: IDLE (gnt=000, d1..d8=0, busy=0) and SHOW (gnt one-hot, busy=1).
REQ-012 The block SHALL register gnt, busy and d1..d8 together, so all three change on the same edge.
REQ-013 In SHOW, each digit k SHALL be {mask_g[8-k], data_g nibble for dk, dp}, where g is the granted index, sampled every cycle; data/mask changes appear one cycle later.
REQ-014 dp SHALL be 0 on d1..d7; d8 dp SHALL equal the registered hold value.
REQ-015 With en=0, the hex field SHALL still carry the nibble; only en blanks the digit.
REQ-016 Selection SHALL be round-robin: the search starts at rr_ptr and takes the first set req bit in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); after a grant to i, rr_ptr = (i+1) mod 3.
REQ-017 In IDLE, any set req bit SHALL produce, on the next edge, SHOW with gnt set by REQ-016 and the dwell counter at 0.
REQ-018 In SHOW, the 27-bit dwell counter SHALL increment each cycle until DWELL-1 and SHALL saturate there.
REQ-019 When the counter = DWELL-1 and hold=0, the next edge SHALL apply REQ-016 selection and reset the counter to 0. The result is the next requester, the same requester if it is the only one requesting, or IDLE if req=000.
REQ-020 While hold=1 and the granted req bit is set, gnt SHALL NOT change; the counter saturates at DWELL-1, and the rotation of REQ-019 occurs on the first edge with hold=0.
REQ-021 If the granted req bit is 0 in any SHOW cycle, the next edge SHALL reselect per REQ-016 (or go to IDLE), regardless of counter value or hold.
REQ-022 gnt SHALL never have more than one bit set, and busy SHALL equal |gnt at all times.

Reset
REQ-023 On a clk edge with rst=1, the block SHALL enter IDLE with gnt=000, busy=0, d1..d8=6'b000000, counter=0 and rr_ptr=0, overriding all other inputs, including mid-SHOW.
REQ-024 The first grant after reset SHALL go to the lowest-index active requester.

Verification (DWELL=4)
REQ-025 Reset, then req=001, data0=0x12345678, mask0=0xFF, hold=0 -> after one edge: gnt=001, busy=1, d1=6'h22, d8=6'h30.
REQ-026 req=111 held constant from IDLE -> gnt sequence 001, 010, 100, 001, each value held exactly 4 cycles.
REQ-027 req=011, hold=1 asserted while gnt=001 -> gnt stays 001 and d8 dp=1 for 10 cycles; hold=0 -> gnt=010 on the next edge.
REQ-028 req=011 with gnt=010, req1 dropped at counter=1 -> next edge gnt=001; then req=000 -> next edge gnt=000, busy=0, all d=0.
REQ-029 mask0=0x0F, data0=0xFFFFFFFF -> d1..d4=6'h1E, d5..d8=6'h3E.
REQ-030 rst=1 for one edge mid-SHOW with req=111 -> IDLE outputs immediately; after rst=0, the first grant is 001.

Source files
------------

// File: rtl/disp_sched.sv
// Round-robin display scheduler: grants one of three requesters the 8-digit display
// for DWELL cycles per page, with hold-to-freeze and immediate reselect on request drop.
module disp_sched #(
    parameter int unsigned DWELL = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [7:0]  mask0,
    input  logic [7:0]  mask1,
    input  logic [7:0]  mask2,
    input  logic        hold,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8,
    output logic [2:0]  gnt,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    localparam logic [26:0] CNT_LAST = 27'(DWELL - 1);

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic [26:0] cnt_q, cnt_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [5:0]  dig_q [8];
    logic [5:0]  dig_d [8];

    logic        reselect;
    logic [1:0]  pick_idx;
    logic [31:0] sel_data;
    logic [7:0]  sel_mask;
    logic        sel_dp;

    // First set request bit scanning from ptr upward, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] r);
        logic [1:0]  idx;
        logic        found;
        int unsigned c;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            c = (32'(ptr) + k) % 3;
            if (!found && r[c[1:0]]) begin
                found = 1'b1;
                idx   = c[1:0];
            end
        end
        return idx;
    endfunction

    always_comb begin
        pick_idx = rr_pick(rr_ptr_q, req);
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        reselect = 1'b0;

        case (state_q)
            IDLE: reselect = |req;
            SHOW: begin
                if ((gnt_q & req) == 3'b000) begin
                    reselect = 1'b1;
                end else if (cnt_q == CNT_LAST && !hold) begin
                    reselect = 1'b1;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            default: reselect = 1'b0;
        endcase

        if (reselect) begin
            cnt_d = '0;
            if (|req) begin
                state_d  = SHOW;
                gnt_d    = 3'b001 << pick_idx;
                rr_ptr_d = (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end

        busy_d = |gnt_d;
    end

    // Digits follow the grant being loaded this edge so gnt and d change together.
    always_comb begin
        sel_data = '0;
        sel_mask = '0;
        case (gnt_d)
            3'b001: begin sel_data = data0; sel_mask = mask0; end
            3'b010: begin sel_data = data1; sel_mask = mask1; end
            3'b100: begin sel_data = data2; sel_mask = mask2; end
            default: begin sel_data = '0; sel_mask = '0; end
        endcase
        sel_dp = hold && (gnt_d != 3'b000);
    end

    for (genvar i = 0; i < 8; i++) begin : g_dig
        assign dig_d[i] = {sel_mask[7-i], sel_data[(7-i)*4 +: 4], (i == 7) ? sel_dp : 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            for (int unsigned i = 0; i < 8; i++) dig_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned i = 0; i < 8; i++) dig_q[i] <= dig_d[i];
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign d1   = dig_q[0];
    assign d2   = dig_q[1];
    assign d3   = dig_q[2];
    assign d4   = dig_q[3];
    assign d5   = dig_q[4];
    assign d6   = dig_q[5];
    assign d7   = dig_q[6];
    assign d8   = dig_q[7];

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with DWELL=4: reset, digit formatting, rotation,
// hold, request drop and mid-page reset, against hand-computed values.
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] data0, data1, data2;
    logic [7:0]  mask0, mask1, mask2;
    logic        hold;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
    logic [2:0]  gnt;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    disp_sched #(.DWELL(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .mask0 (mask0),
        .mask1 (mask1),
        .mask2 (mask2),
        .hold  (hold),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .d6    (d6),
        .d7    (d7),
        .d8    (d8),
        .gnt   (gnt),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_gnt;
    logic [5:0] d1_tab [3];
    logic [5:0] d8_tab [3];
    int unsigned gi;

    initial begin
        d1_tab = '{6'h22, 6'h34, 6'h0A};
        d8_tab = '{6'h30, 6'h00, 6'h38};

        rst = 1'b1; req = 3'b000; hold = 1'b0;
        data0 = 32'h12345678; mask0 = 8'hFF;
        data1 = 32'hA0000000; mask1 = 8'h80;
        data2 = 32'h5000000C; mask2 = 8'h01;
        tick(); tick();
        check_val("rst_gnt",  32'(gnt),  32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_d1",   32'(d1),   32'h0);
        check_val("rst_d8",   32'(d8),   32'h0);

        // First grant and digit formatting
        rst = 1'b0; req = 3'b001;
        tick();
        check_val("first_gnt",  32'(gnt),  32'h1);
        check_val("first_busy", 32'(busy), 32'h1);
        check_val("first_d1",   32'(d1),   32'h22);
        check_val("first_d2",   32'(d2),   32'h24);
        check_val("first_d8",   32'(d8),   32'h30);

        // Enable blanks digit but hex field still carries nibble
        mask0 = 8'h0F; data0 = 32'hFFFFFFFF;
        tick();
        check_val("mask_gnt", 32'(gnt), 32'h1);
        check_val("mask_d1",  32'(d1),  32'h1E);
        check_val("mask_d4",  32'(d4),  32'h1E);
        check_val("mask_d5",  32'(d5),  32'h3E);
        check_val("mask_d8",  32'(d8),  32'h3E);
        data0 = 32'h12345678; mask0 = 8'hFF;

        // Full rotation with all requesters, 4 cycles per page
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b111;
        for (int unsigned n = 1; n <= 16; n++) begin
            tick();
            gi = ((n - 1) / 4) % 3;
            exp_gnt = 3'b001 << gi;
            check_val($sformatf("rot_gnt_%0d", n), 32'(gnt), 32'(exp_gnt));
            check_val($sformatf("rot_busy_%0d", n), 32'(busy), 32'h1);
            check_val($sformatf("rot_d1_%0d", n), 32'(d1), 32'(d1_tab[gi]));
            check_val($sformatf("rot_d8_%0d", n), 32'(d8), 32'(d8_tab[gi]));
        end

        // Reset mid-page; pointer must restart at requester 0
        rst = 1'b1;
        tick();
        check_val("midrst_gnt",  32'(gnt),  32'h0);
        check_val("midrst_busy", 32'(busy), 32'h0);
        check_val("midrst_d1",   32'(d1),   32'h0);
        rst = 1'b0;
        tick();
        check_val("postrst_gnt", 32'(gnt), 32'h1);

        // Hold freezes rotation; d8 dp shows hold
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b011;
        tick();
        check_val("hold_start_gnt", 32'(gnt), 32'h1);
        hold = 1'b1;
        for (int unsigned n = 1; n <= 10; n++) begin
            tick();
            check_val($sformatf("hold_gnt_%0d", n), 32'(gnt), 32'h1);
            check_val($sformatf("hold_d8_%0d", n),  32'(d8),  32'h31);
        end
        hold = 1'b0;
        tick();
        check_val("unhold_gnt", 32'(gnt), 32'h2);
        check_val("unhold_d1",  32'(d1),  32'h34);
        check_val("unhold_d8",  32'(d8),  32'h00);

        // Drop granted request mid-page, then drop all
        tick();
        check_val("drop_pre_gnt", 32'(gnt), 32'h2);
        req = 3'b001;
        tick();
        check_val("drop_gnt", 32'(gnt), 32'h1);
        check_val("drop_d1",  32'(d1),  32'h22);
        req = 3'b000;
        tick();
        check_val("idle_gnt",  32'(gnt),  32'h0);
        check_val("idle_busy", 32'(busy), 32'h0);
        check_val("idle_d1",   32'(d1),   32'h0);
        check_val("idle_d8",   32'(d8),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
